vga_mode_sequencer: RTL and testbench

Sequencer that owns the VGA sync generator's `mode` and `reset` inputs. It accepts mode-change requests over a valid/ready handshake and applies each change only at a frame boundary. Each change holds the sync generator in reset, then blanks video for a settle period so the monitor can relock. It sits between the host/config logic and the sync generator in the vga_spi_rom video path.

---
 rtl/vga_mode_sequencer.sv | 157 +++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer.sv
// rtl/vga_mode_sequencer.sv - frame-aligned VGA mode-change sequencer
//
// Owns the sync generator's mode and reset inputs. Mode-change requests are
// accepted over a valid/ready handshake, applied at the next frame end, then
// the sync generator is held in reset for HOLD_CYCLES and video is blanked
// for SETTLE_FRAMES frames so the monitor can relock. Reset behaves like a
// change sequence to INIT_MODE, starting in HOLD.
//
// Optional feature: define VGA_MODE_SEQ_SKIP_SAME_EN to complete a request
// for the already-active mode immediately (done next cycle, no reset/blank).
//
// Ports:
//   clk        pixel clock
//   reset_n    asynchronous active-low reset
//   req_valid  mode-change request valid
//   req_mode   requested mode (0 = 640x480, 1 = 1440x900/4)
//   req_ready  high only in IDLE; transfer = req_valid && req_ready
//   hmax_in    sync generator o_hmax
//   vmax_in    sync generator o_vmax
//   vga_mode   sync generator mode
//   vga_reset  sync generator reset (active-high)
//   blank      force RGB to black
//   busy       high in any state other than IDLE
//   done       one-cycle pulse on the first IDLE cycle after a sequence

module vga_mode_sequencer #(
    parameter int unsigned INIT_MODE     = 0,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_valid,
    input  logic req_mode,
    output logic req_ready,
    input  logic hmax_in,
    input  logic vmax_in,
    output logic vga_mode,
    output logic vga_reset,
    output logic blank,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_EOF = 2'd1,
        S_HOLD     = 2'd2,
        S_SETTLE   = 2'd3
    } state_t;

    localparam logic       INIT_BIT    = INIT_MODE[0];
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    // Wraps to 4'hF when SETTLE_FRAMES is 0; SETTLE is never entered then.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
    localparam bit         NO_SETTLE   = (SETTLE_FRAMES == 0);

    state_t     state, state_next;
    logic [7:0] hcnt, hcnt_next;
    logic [3:0] fcnt, fcnt_next;
    logic       pend, pend_next;
    logic       mode_q, mode_next;
    logic       done_q, done_next;
    logic       eof;

    assign eof = hmax_in & vmax_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_HOLD;
            hcnt   <= 8'd0;
            fcnt   <= 4'd0;
            pend   <= INIT_BIT;
            mode_q <= INIT_BIT;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            hcnt   <= hcnt_next;
            fcnt   <= fcnt_next;
            pend   <= pend_next;
            mode_q <= mode_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        fcnt_next  = fcnt;
        pend_next  = pend;
        mode_next  = mode_q;
        done_next  = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef VGA_MODE_SEQ_SKIP_SAME_EN
                    if (req_mode == mode_q) begin
                        done_next = 1'b1;
                    end else begin
                        pend_next  = req_mode;
                        state_next = S_WAIT_EOF;
                    end
`else
                    pend_next  = req_mode;
                    state_next = S_WAIT_EOF;
`endif
                end
            end

            // Old mode keeps running until the frame ends so no partial
            // frame is ever drawn in the new timing.
            S_WAIT_EOF: begin
                if (eof) begin
                    mode_next  = pend;
                    hcnt_next  = 8'd0;
                    state_next = S_HOLD;
                end
            end

            // eof cannot occur here since the generator is held in reset.
            S_HOLD: begin
                hcnt_next = hcnt + 8'd1;
                if (hcnt == HOLD_LAST) begin
                    fcnt_next = 4'd0;
                    if (NO_SETTLE) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
            end

            S_SETTLE: begin
                if (eof) begin
                    if (fcnt == SETTLE_LAST) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        fcnt_next = fcnt + 4'd1;
                    end
                end
            end

            default: state_next = S_HOLD;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign vga_reset = (state == S_HOLD);
    assign blank     = (state == S_HOLD) || (state == S_SETTLE);
    assign vga_mode  = mode_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb/tb_vga_mode_sequencer.sv - directed table-driven bench for vga_mode_sequencer

module tb_vga_mode_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: INIT_MODE=0, HOLD_CYCLES=4, SETTLE_FRAMES=2
    logic reset_n = 1'b1;
    logic req_valid = 1'b0, req_mode = 1'b0, hmax_in = 1'b0, vmax_in = 1'b0;
    logic req_ready, vga_mode, vga_reset, blank, busy, done;

    // Instance b: INIT_MODE=1, HOLD_CYCLES=3, SETTLE_FRAMES=0
    logic b_reset_n = 1'b1;
    logic b_valid = 1'b0, b_mode = 1'b0, b_hmax = 1'b0, b_vmax = 1'b0;
    logic b_ready, b_vga_mode, b_vga_reset, b_blank, b_busy, b_done;

    vga_mode_sequencer #(.INIT_MODE(0), .HOLD_CYCLES(4), .SETTLE_FRAMES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .hmax_in(hmax_in), .vmax_in(vmax_in),
        .vga_mode(vga_mode), .vga_reset(vga_reset), .blank(blank), .busy(busy), .done(done)
    );

    vga_mode_sequencer #(.INIT_MODE(1), .HOLD_CYCLES(3), .SETTLE_FRAMES(0)) dut_b (
        .clk(clk), .reset_n(b_reset_n), .req_valid(b_valid), .req_mode(b_mode),
        .req_ready(b_ready), .hmax_in(b_hmax), .vmax_in(b_vmax),
        .vga_mode(b_vga_mode), .vga_reset(b_vga_reset), .blank(b_blank), .busy(b_busy), .done(b_done)
    );

    // Output bundle order: {vga_mode, vga_reset, blank, busy, req_ready, done}
    wire [5:0] out_a = {vga_mode, vga_reset, blank, busy, req_ready, done};
    wire [5:0] out_b = {b_vga_mode, b_vga_reset, b_blank, b_busy, b_ready, b_done};

    typedef struct {
        logic       rst;
        logic       v;
        logic       m;
        logic       h;
        logic       vv;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b ({mode,reset,blank,busy,ready,done})", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic m, input logic h, input logic vv);
        req_valid = v; req_mode = m; hmax_in = h; vmax_in = vv;
        tick();
    endtask

    task automatic drive_b(input logic v, input logic m, input logic h, input logic vv);
        b_valid = v; b_mode = m; b_hmax = h; b_vmax = vv;
        tick();
    endtask

    initial begin
        // rst, valid, mode, hmax, vmax, expected outputs
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011100, "reset"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b011100, "reset_inputs_ignored"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011100, "po_hold1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011100, "po_hold2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011100, "po_hold3"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001100, "po_settle"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b001100, "po_settle_eof1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001100, "po_settle_wait"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b001100, "po_settle_hmax_only"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000011, "po_done"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000100, "accept_during_done"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, "wait_mode_toggle"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100, "wait_valid_ignored"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, "wait_vmax_only"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111100, "eof_apply"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111100, "chg_hold1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111100, "chg_hold2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111100, "chg_hold3"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b101100, "chg_settle"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101100, "settle_valid_ignored"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b101100, "chg_settle_eof1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b100011, "chg_done"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100010, "chg_done_clear"});

        b_reset_n = 1'b0;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst;
            drive_a(vecs[i].v, vecs[i].m, vecs[i].h, vecs[i].vv);
            check(vecs[i].name, out_a, vecs[i].exp);
        end

        // Same-mode request while in mode 1
        drive_a(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef VGA_MODE_SEQ_SKIP_SAME_EN
        check("skip_same_done", out_a, 6'b100011);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("skip_same_clear", out_a, 6'b100010);
`else
        check("same_mode_wait", out_a, 6'b100100);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("same_mode_hold", out_a, 6'b111100);
        for (int i = 0; i < 3; i++) drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("same_mode_hold_last", out_a, 6'b111100);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("same_mode_settle", out_a, 6'b101100);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("same_mode_done", out_a, 6'b100011);
`endif

        // Full change back to mode 0
        drive_a(1'b1, 1'b0, 1'b0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("to0_hold", out_a, 6'b011100);
        for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("to0_done", out_a, 6'b000011);

        // Change to mode 1, aborted by reset in SETTLE with fcnt=1
        drive_a(1'b1, 1'b1, 1'b0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_hold", out_a, 6'b111100);
        for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_settle_f1", out_a, 6'b101100);
        reset_n = 1'b0;
        #1;
        check("abort_async_reset", out_a, 6'b011100);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_no_done", out_a, 6'b011100);
        reset_n = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_hold", out_a, 6'b011100);
        for (int i = 0; i < 3; i++) drive_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_settle", out_a, 6'b001100);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        drive_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("restart_done", out_a, 6'b000011);

        // Instance b: no settle period, INIT_MODE=1, HOLD_CYCLES=3
        check("b_reset", out_b, 6'b111100);
        b_reset_n = 1'b1;
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_po_hold1", out_b, 6'b111100);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_po_hold2", out_b, 6'b111100);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_po_done", out_b, 6'b100011);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_po_clear", out_b, 6'b100010);
        drive_b(1'b1, 1'b0, 1'b0, 1'b0);
        check("b_wait", out_b, 6'b100100);
        drive_b(1'b0, 1'b1, 1'b1, 1'b1);
        check("b_hold", out_b, 6'b011100);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_hold_last", out_b, 6'b011100);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_done", out_b, 6'b000011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
